// File: rtl/adder_serial_arb_pkg.sv
// adder_serial_arb_pkg: shared types and elaboration helpers for the nibble-serial adder.
//   state_e    - controller state encoding (idle, nibble run, result hold)
//   nib_count  - number of 4-bit steps for a given operand width
//   idx_width  - bits needed for the nibble index, never less than one
//   width_ok   - legality check for the operand width
package adder_serial_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NibBits = 4;

    function automatic int unsigned nib_count(input int unsigned width);
        return width / NibBits;
    endfunction

    // ceil(log2(nib)) clamped to a minimum of 1 so a single-step index still has a bit.
    function automatic int unsigned idx_width(input int unsigned nib);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < nib) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width >= NibBits) && ((width % NibBits) == 0);
    endfunction

endpackage

// File: rtl/adder_serial_arb_if.sv
// adder_serial_arb_if: request/response bundle between two clients and the shared adder.
//   req0_* / req1_* - valid/ready request channels carrying operands a, b and carry-in
//   resp_*          - valid/ready response channel with {carry_out, sum} and owner id
// Modports: master = client/consumer side, slave = adder side.
interface adder_serial_arb_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH:0]   resp_sum;
    logic             resp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  resp_valid, resp_sum, resp_id,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output resp_valid, resp_sum, resp_id,
        input  resp_ready
    );

endinterface

// File: rtl/adder_serial_arb_cla4.sv
// adder_serial_arb_cla4: 4-bit carry-lookahead adder slice.
//   cin - carry into bit 0
//   in1 - first 4-bit operand
//   in2 - second 4-bit operand
//   out - {carry_out, sum[3:0]}
module adder_serial_arb_cla4 (
    input  logic       cin,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic [4:0] out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = in1 & in2;
    assign p = in1 ^ in2;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign out = {c[4], p ^ c[3:0]};

endmodule

// File: rtl/adder_serial_arb.sv
// adder_serial_arb: two-client round-robin front end for a nibble-serial WIDTH-bit adder.
// One operation is accepted at a time, summed 4 bits per cycle LSB first through a
// single shared CLA slice, then held until the consumer takes it.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - request/response bundle (slave side)
//   busy - high while an operation is running or its result is being held
module adder_serial_arb
    import adder_serial_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    adder_serial_arb_if.slave bus,
    output logic              busy
);

    localparam int unsigned     NIB     = nib_count(WIDTH);
    localparam int unsigned     IdxW    = idx_width(NIB);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("adder_serial_arb: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             id_q, id_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             last_q, last_d;

    logic             grant_id;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       slice_out;

    // With both requesting, the one not served last wins; otherwise the lone requester.
    assign grant_id = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;

    assign bus.req0_ready = (state_q == StIdle) & bus.req0_valid & ~grant_id;
    assign bus.req1_ready = (state_q == StIdle) & bus.req1_valid & grant_id;

    assign bus.resp_valid = (state_q == StDone);
    assign bus.resp_sum   = sum_q;
    assign bus.resp_id    = id_q;
    assign busy           = (state_q != StIdle);

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            if (idx_q == IdxW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    adder_serial_arb_cla4 u_slice (
        .cin (carry_q),
        .in1 (nib_a),
        .in2 (nib_b),
        .out (slice_out)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        id_d    = id_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        last_d  = last_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req0_ready | bus.req1_ready) begin
                    a_d     = bus.req1_ready ? bus.req1_a : bus.req0_a;
                    b_d     = bus.req1_ready ? bus.req1_b : bus.req0_b;
                    carry_d = bus.req1_ready ? bus.req1_cin : bus.req0_cin;
                    id_d    = bus.req1_ready;
                    last_d  = bus.req1_ready;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int unsigned i = 0; i < NIB; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[4*i +: 4] = slice_out[3:0];
                    end
                end
                carry_d = slice_out[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    sum_d[WIDTH] = slice_out[4];
                    state_d      = StDone;
                end
            end
            StDone: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b1;  // requester 0 wins the first tie
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_adder_serial_arb.sv
// tb_adder_serial_arb: directed bench for adder_serial_arb at WIDTH=16 and WIDTH=4.
module tb_adder_serial_arb;

    logic clk = 1'b0;
    logic rst;
    logic busy16;
    logic busy4;
    int   n_vec      = 0;
    int   n_err      = 0;
    int   both_ready = 0;

    always #5 clk = ~clk;

    adder_serial_arb_if #(.WIDTH(16)) if16 ();
    adder_serial_arb_if #(.WIDTH(4))  if4 ();

    adder_serial_arb #(.WIDTH(16)) dut16 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if16),
        .busy (busy16)
    );

    adder_serial_arb #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if4),
        .busy (busy4)
    );

    always @(negedge clk) begin
        if (if16.req0_ready && if16.req1_ready) both_ready++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation, wait (bounded) for ready, let the accept edge pass, drop valid.
    task automatic issue16(input logic id, input logic [15:0] a, input logic [15:0] b,
                           input logic cin);
        int n;
        if (id) begin
            if16.req1_valid = 1'b1; if16.req1_a = a; if16.req1_b = b; if16.req1_cin = cin;
        end else begin
            if16.req0_valid = 1'b1; if16.req0_a = a; if16.req0_b = b; if16.req0_cin = cin;
        end
        #1;
        n = 0;
        while (!(id ? if16.req1_ready : if16.req0_ready) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        if (id) if16.req1_valid = 1'b0;
        else    if16.req0_valid = 1'b0;
    endtask

    task automatic wait_resp16(output int lat);
        lat = 0;
        while (!if16.resp_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (lat >= 50) check("resp_timeout", 32'(lat), 32'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        if16.req0_valid = 1'b0; if16.req0_a = '0; if16.req0_b = '0; if16.req0_cin = 1'b0;
        if16.req1_valid = 1'b0; if16.req1_a = '0; if16.req1_b = '0; if16.req1_cin = 1'b0;
        if16.resp_ready = 1'b1;
        if4.req0_valid = 1'b0; if4.req0_a = '0; if4.req0_b = '0; if4.req0_cin = 1'b0;
        if4.req1_valid = 1'b0; if4.req1_a = '0; if4.req1_b = '0; if4.req1_cin = 1'b0;
        if4.resp_ready = 1'b1;

        tick();
        tick();
        check("rst_resp_valid", 32'(if16.resp_valid), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_resp_sum", 32'(if16.resp_sum), 32'd0);
        check("rst_resp_id", 32'(if16.resp_id), 32'd0);
        check("rst_busy_w4", 32'(busy4), 32'd0);
        rst = 1'b0;

        // Basic add, latency from accept edge
        issue16(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        check("t1_busy_run", 32'(busy16), 32'd1);
        wait_resp16(lat);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_sum", 32'(if16.resp_sum), 32'h02233);
        check("t1_id", 32'(if16.resp_id), 32'd0);
        tick();
        check("t1_idle_valid", 32'(if16.resp_valid), 32'd0);
        check("t1_idle_busy", 32'(busy16), 32'd0);

        // Full ripple through all nibbles
        issue16(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        wait_resp16(lat);
        check("t2_latency", 32'(lat), 32'd4);
        check("t2_sum", 32'(if16.resp_sum), 32'h10000);
        check("t2_id", 32'(if16.resp_id), 32'd1);
        tick();
        issue16(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        wait_resp16(lat);
        check("t3_sum", 32'(if16.resp_sum), 32'h10000);
        check("t3_id", 32'(if16.resp_id), 32'd1);
        tick();

        // Round-robin with both requesters held valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if16.req0_valid = 1'b1; if16.req0_a = 16'h0001; if16.req0_b = 16'h0001;
        if16.req0_cin = 1'b0;
        if16.req1_valid = 1'b1; if16.req1_a = 16'h0100; if16.req1_b = 16'h0100;
        if16.req1_cin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_resp16(lat);
            check("arb_id", 32'(if16.resp_id), 32'(i % 2));
            check("arb_sum", 32'(if16.resp_sum), (i % 2 == 1) ? 32'h00200 : 32'h00002);
            if (i == 3) begin
                if16.req0_valid = 1'b0;
                if16.req1_valid = 1'b0;
            end
            tick();
        end

        // Backpressure with a pending request from the other client
        if16.resp_ready = 1'b0;
        issue16(1'b0, 16'hABCD, 16'h1111, 1'b1);
        if16.req1_valid = 1'b1; if16.req1_a = 16'h0001; if16.req1_b = 16'h0002;
        if16.req1_cin = 1'b0;
        wait_resp16(lat);
        check("bp_latency", 32'(lat), 32'd4);
        check("bp_sum", 32'(if16.resp_sum), 32'h0BCDF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(if16.resp_valid), 32'd1);
            check("bp_hold_sum", 32'(if16.resp_sum), 32'h0BCDF);
            check("bp_hold_id", 32'(if16.resp_id), 32'd0);
            check("bp_hold_busy", 32'(busy16), 32'd1);
            check("bp_hold_ready", {30'd0, if16.req1_ready, if16.req0_ready}, 32'd0);
        end
        if16.resp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(if16.resp_valid), 32'd0);
        check("bp_release_busy", 32'(busy16), 32'd0);
        check("bp_pending_ready", 32'(if16.req1_ready), 32'd1);
        tick();
        if16.req1_valid = 1'b0;
        check("bp_pending_busy", 32'(busy16), 32'd1);
        wait_resp16(lat);
        check("bp_pending_latency", 32'(lat), 32'd4);
        check("bp_pending_sum", 32'(if16.resp_sum), 32'h00003);
        check("bp_pending_id", 32'(if16.resp_id), 32'd1);
        tick();

        // Reset while idx==2
        issue16(1'b0, 16'h5555, 16'h5555, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(if16.resp_valid), 32'd0);
        check("midrst_busy", 32'(busy16), 32'd0);
        if16.req0_valid = 1'b1; if16.req0_a = 16'h00FF; if16.req0_b = 16'h0001;
        if16.req0_cin = 1'b0;
        #1;
        check("midrst_ready", 32'(if16.req0_ready), 32'd1);
        issue16(1'b0, 16'h00FF, 16'h0001, 1'b0);
        wait_resp16(lat);
        check("midrst_latency", 32'(lat), 32'd4);
        check("midrst_sum", 32'(if16.resp_sum), 32'h00100);
        check("midrst_id", 32'(if16.resp_id), 32'd0);
        tick();

        // WIDTH=4 exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int n;
                    if4.req0_valid = 1'b1;
                    if4.req0_a = a[3:0];
                    if4.req0_b = b[3:0];
                    if4.req0_cin = c[0];
                    #1;
                    n = 0;
                    while (!if4.req0_ready && n < 20) begin
                        tick();
                        n++;
                    end
                    if (n >= 20) check("w4_accept_timeout", 32'(n), 32'd0);
                    @(posedge clk);
                    #1;
                    if4.req0_valid = 1'b0;
                    n = 0;
                    while (!if4.resp_valid && n < 20) begin
                        tick();
                        n++;
                    end
                    check("w4_latency", 32'(n), 32'd1);
                    check("w4_sum", 32'(if4.resp_sum), 32'(a + b + c));
                    tick();
                end
            end
        end

        check("never_both_ready", 32'(both_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
